// File: rtl/g3_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : g3_pkg
//  Purpose : Shared widths, constants, FSM encoding and 5-tuple field layout
//            for the G3 lookup path (chain walker and search stage).
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package g3_pkg;

    localparam int IDX_W   = 11;
    localparam int RID_W   = 11;
    localparam int TUPLE_W = 104;
    localparam int HOPS_W  = 7;

    // Chain terminator for next_index / request head.
    localparam logic [IDX_W-1:0] NULL_INDEX = 11'h7FF;
    // ruleID reported when nothing matched; also the "worse than any rule" seed.
    localparam logic [RID_W-1:0] NO_RULE    = 11'h7FF;

    // 5-tuple field offsets: {proto, dstPort, srcPort, dstIP, srcIP}
    localparam int TUP_SRCIP_LSB   = 0;
    localparam int TUP_DSTIP_LSB   = 32;
    localparam int TUP_SRCPORT_LSB = 64;
    localparam int TUP_DSTPORT_LSB = 80;
    localparam int TUP_PROTO_LSB   = 96;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EVAL  = 3'd3,
        ST_DONE  = 3'd4
    } walk_state_t;

    // Assemble a tuple from its fields in the layout above.
    function automatic logic [TUPLE_W-1:0] pack_tuple(
        input logic [7:0]  proto,
        input logic [15:0] dst_port,
        input logic [15:0] src_port,
        input logic [31:0] dst_ip,
        input logic [31:0] src_ip
    );
        logic [TUPLE_W-1:0] t;
        t = '0;
        t[TUP_PROTO_LSB   +: 8]  = proto;
        t[TUP_DSTPORT_LSB +: 16] = dst_port;
        t[TUP_SRCPORT_LSB +: 16] = src_port;
        t[TUP_DSTIP_LSB   +: 32] = dst_ip;
        t[TUP_SRCIP_LSB   +: 32] = src_ip;
        return t;
    endfunction

endpackage : g3_pkg
`default_nettype wire

// File: rtl/g3_chain_walker.sv
`default_nettype none
// ============================================================================
//  Module  : g3_chain_walker
//  Purpose : Lookup controller in front of the G3 table search stage. Takes one
//            5-tuple + chain head, walks the next_index linked list one hop at
//            a time through the search stage, and returns the lowest matching
//            ruleID. One lookup in flight; valid/ready on both sides.
//  Ports   : clk, rst_n                      clock / async active-low reset
//            req_valid/req_ready/req_tuple/req_head    request channel
//            search_index, tupleData         drive into the search stage
//            tbl_match/tbl_ruleID/tbl_next   search stage results
//            resp_valid/resp_ready/resp_match/resp_ruleID/resp_hops/
//            resp_overflow                   response channel
//  Rev     : 1.0  initial release
// ============================================================================
module g3_chain_walker
    import g3_pkg::*;
#(
    parameter int                        TBL_LAT    = 2,
    parameter int                        MAX_HOPS   = 64,
    parameter logic [g3_pkg::IDX_W-1:0]  NULL_INDEX = g3_pkg::NULL_INDEX
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [g3_pkg::TUPLE_W-1:0]   req_tuple,
    input  logic [g3_pkg::IDX_W-1:0]     req_head,
    output logic [g3_pkg::IDX_W-1:0]     search_index,
    output logic [g3_pkg::TUPLE_W-1:0]   tupleData,
    input  logic                         tbl_match,
    input  logic [g3_pkg::RID_W-1:0]     tbl_ruleID,
    input  logic [g3_pkg::IDX_W-1:0]     tbl_next,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic                         resp_match,
    output logic [g3_pkg::RID_W-1:0]     resp_ruleID,
    output logic [g3_pkg::HOPS_W-1:0]    resp_hops,
    output logic                         resp_overflow
);

    // Wait counter only needs to hold TBL_LAT-1.
    localparam int CNT_W = (TBL_LAT > 1) ? $clog2(TBL_LAT) : 1;

    walk_state_t          r_state;
    walk_state_t          w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_search_index;
    logic [TUPLE_W-1:0]   r_tuple;
    logic [RID_W-1:0]     r_best;
    logic                 r_hit;
    logic [HOPS_W-1:0]    r_hops;
    logic                 r_ovf;
    logic                 r_resp_valid;

    logic [HOPS_W-1:0]    w_hops_inc;
    logic                 w_hop_limit;
    logic                 w_better;
    logic                 w_req_ready;

    assign w_hops_inc  = r_hops + HOPS_W'(1);
    assign w_hop_limit = (w_hops_inc == HOPS_W'(MAX_HOPS));
    // Strict less-than: an equal ruleID later in the chain keeps the earlier hit.
    assign w_better    = tbl_match && (tbl_ruleID < r_best);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state / combinational outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_req_ready = 1'b1;
                if (req_valid) begin
                    // Empty chain: answer immediately without touching the table.
                    w_state_nxt = (req_head == NULL_INDEX) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = (TBL_LAT == 1) ? ST_EVAL : ST_WAIT;
            end
            ST_WAIT: begin
                // Counter reaches 0 on this cycle's decrement.
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = ST_EVAL;
                end
            end
            ST_EVAL: begin
                // Terminator wins over the hop limit.
                if (tbl_next == NULL_INDEX || w_hop_limit) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_DONE: begin
                if (resp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt          <= '0;
            r_search_index <= NULL_INDEX;
            r_tuple        <= '0;
            r_best         <= NO_RULE;
            r_hit          <= 1'b0;
            r_hops         <= '0;
            r_ovf          <= 1'b0;
            r_resp_valid   <= 1'b0;
        end else begin
            // Registered valid tracks residency in DONE, so it stays high
            // (with frozen fields) until the consumer takes it.
            r_resp_valid <= (w_state_nxt == ST_DONE);
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_tuple <= req_tuple;
                        r_best  <= NO_RULE;
                        r_hit   <= 1'b0;
                        r_hops  <= '0;
                        r_ovf   <= 1'b0;
                        if (req_head != NULL_INDEX) begin
                            r_search_index <= req_head;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_cnt <= CNT_W'(TBL_LAT - 1);
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                ST_EVAL: begin
                    r_hops <= w_hops_inc;
                    if (w_better) begin
                        r_best <= tbl_ruleID;
                        r_hit  <= 1'b1;
                    end
                    if (tbl_next != NULL_INDEX) begin
                        if (w_hop_limit) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_search_index <= tbl_next;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign req_ready     = w_req_ready;
    assign search_index  = r_search_index;
    assign tupleData     = r_tuple;
    assign resp_valid    = r_resp_valid;
    assign resp_match    = r_hit;
    assign resp_ruleID   = r_best;
    assign resp_hops     = r_hops;
    assign resp_overflow = r_ovf;

endmodule : g3_chain_walker
`default_nettype wire

// File: tb/tb_g3_chain_walker.sv
`default_nettype none
// ============================================================================
//  Module  : tb_g3_chain_walker
//  Purpose : Self-checking bench for g3_chain_walker with a behavioural
//            search-stage table (TBL_LAT=2) and a chain-walk reference model.
//  Ports   : none
//  Rev     : 1.0  initial release
// ============================================================================
module tb_g3_chain_walker;

    localparam int          TBL_LAT  = 2;
    localparam int          MAX_HOPS = 4;
    localparam logic [10:0] NUL      = 11'h7FF;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [103:0]  req_tuple;
    logic [10:0]   req_head;
    logic [10:0]   search_index;
    logic [103:0]  tupleData;
    logic          tbl_match;
    logic [10:0]   tbl_ruleID;
    logic [10:0]   tbl_next;
    logic          resp_valid;
    logic          resp_ready;
    logic          resp_match;
    logic [10:0]   resp_ruleID;
    logic [6:0]    resp_hops;
    logic          resp_overflow;

    int checks = 0;
    int fails  = 0;

    g3_chain_walker #(
        .TBL_LAT    (TBL_LAT),
        .MAX_HOPS   (MAX_HOPS),
        .NULL_INDEX (NUL)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_tuple     (req_tuple),
        .req_head      (req_head),
        .search_index  (search_index),
        .tupleData     (tupleData),
        .tbl_match     (tbl_match),
        .tbl_ruleID    (tbl_ruleID),
        .tbl_next      (tbl_next),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_match    (resp_match),
        .resp_ruleID   (resp_ruleID),
        .resp_hops     (resp_hops),
        .resp_overflow (resp_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural search stage: table contents plus a TBL_LAT-deep index pipe.
    bit          m_match [2048];
    logic [10:0] m_rid   [2048];
    logic [10:0] m_next  [2048];
    logic [10:0] p1 = 11'h7FF;
    logic [10:0] p2 = 11'h7FF;

    always @(posedge clk) begin
        p1 <= search_index;
        p2 <= p1;
    end
    assign tbl_match  = m_match[p2];
    assign tbl_ruleID = m_rid[p2];
    assign tbl_next   = m_next[p2];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: walk the linked list directly.
    task automatic model(input logic [10:0] head, output bit hit, output logic [10:0] best,
                         output int hops, output bit ovf);
        logic [10:0] idx;
        idx  = head;
        hit  = 1'b0;
        best = NUL;
        hops = 0;
        ovf  = 1'b0;
        while (idx != NUL) begin
            hops++;
            if (m_match[idx] && m_rid[idx] < best) begin
                best = m_rid[idx];
                hit  = 1'b1;
            end
            if (m_next[idx] == NUL) break;
            if (hops == MAX_HOPS) begin
                ovf = 1'b1;
                break;
            end
            idx = m_next[idx];
        end
    endtask

    task automatic set_entry(input int idx, input bit m, input logic [10:0] rid, input logic [10:0] nxt);
        m_match[idx] = m;
        m_rid[idx]   = rid;
        m_next[idx]  = nxt;
    endtask

    function automatic logic [103:0] rand_tuple();
        return {$urandom(), $urandom(), $urandom(), 8'($urandom())};
    endfunction

    // One full lookup. Called and returns on a negedge.
    // stall: cycles resp_ready is held low with a competing request asserted.
    task automatic run_lookup(input string tag, input logic [10:0] head, input int stall);
        bit          e_hit;
        logic [10:0] e_best;
        int          e_hops;
        bit          e_ovf;
        int          lat;
        int          guard;
        int          e_lat;
        logic [103:0] tup;

        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_req_ready_idle"}, 128'(req_ready), 128'(1));

        model(head, e_hit, e_best, e_hops, e_ovf);
        e_lat = (e_hops == 0) ? 1 : e_hops * (TBL_LAT + 1) + 1;
        tup   = rand_tuple();

        req_valid = 1'b1;
        req_head  = head;
        req_tuple = tup;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_head  = 11'($urandom());
        req_tuple = rand_tuple();

        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid && lat < 400);

        check({tag, "_latency"}, 128'(lat),          128'(e_lat));
        check({tag, "_match"},   128'(resp_match),   128'(e_hit));
        check({tag, "_ruleID"},  128'(resp_ruleID),  128'(e_best));
        check({tag, "_hops"},    128'(resp_hops),    128'(e_hops));
        check({tag, "_overflow"},128'(resp_overflow),128'(e_ovf));
        check({tag, "_tuple"},   128'(tupleData),    128'(tup));

        if (stall > 0) begin
            req_valid = 1'b1;
            req_head  = 11'd3;
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                check({tag, "_stall_valid"}, 128'(resp_valid), 128'(1));
                check({tag, "_stall_rdy"},   128'(req_ready),  128'(0));
                check({tag, "_stall_fields"},
                      128'({resp_match, resp_ruleID, resp_hops, resp_overflow}),
                      128'({e_hit, e_best, 7'(e_hops), e_ovf}));
                check({tag, "_stall_tuple"}, 128'(tupleData), 128'(tup));
            end
            req_valid = 1'b0;
        end

        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        @(negedge clk);
        check({tag, "_resp_cleared"}, 128'(resp_valid), 128'(0));
        check({tag, "_back_idle"},    128'(req_ready),  128'(1));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req_ready"},  128'(req_ready),     128'(1));
        check({tag, "_resp_valid"}, 128'(resp_valid),    128'(0));
        check({tag, "_match"},      128'(resp_match),    128'(0));
        check({tag, "_ruleID"},     128'(resp_ruleID),   128'(NUL));
        check({tag, "_hops"},       128'(resp_hops),     128'(0));
        check({tag, "_overflow"},   128'(resp_overflow), 128'(0));
        check({tag, "_sidx"},       128'(search_index),  128'(NUL));
        check({tag, "_tuple"},      128'(tupleData),     128'(0));
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_head   = NUL;
        req_tuple  = '0;
        resp_ready = 1'b0;
        for (int i = 0; i < 2048; i++) set_entry(i, 1'b0, 11'd0, NUL);

        repeat (3) @(negedge clk);
        check_reset_values("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);

        // 1: 5 -> 9 -> end, both match; lower ruleID on second hop wins
        set_entry(5, 1'b1, 11'd40, 11'd9);
        set_entry(9, 1'b1, 11'd12, NUL);
        run_lookup("t1_two_hop", 11'd5, 0);

        // 2: empty chain
        run_lookup("t2_null_head", NUL, 0);

        // 3: no matches along 3 -> 4 -> end
        set_entry(3, 1'b0, 11'd5, 11'd4);
        set_entry(4, 1'b0, 11'd6, NUL);
        run_lookup("t3_nomatch", 11'd3, 0);

        // 4a: loop 1 -> 2 -> 1 truncated at MAX_HOPS
        set_entry(1, 1'b0, 11'd0, 11'd2);
        set_entry(2, 1'b0, 11'd0, 11'd1);
        run_lookup("t4_loop", 11'd1, 0);

        // 4b: terminator on exactly the MAX_HOPS-th hop is not overflow;
        //     tie on ruleID 20 keeps the earlier hit
        set_entry(10, 1'b1, 11'd20, 11'd11);
        set_entry(11, 1'b1, 11'd20, 11'd12);
        set_entry(12, 1'b0, 11'd1,  11'd13);
        set_entry(13, 1'b1, 11'd25, NUL);
        run_lookup("t4_term_at_limit", 11'd10, 0);

        // 5: consumer stalls for 10 cycles with a competing request
        run_lookup("t5_stall", 11'd5, 10);
        // The competing request must not have started a lookup.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_no_phantom", 128'(resp_valid), 128'(0));
        end

        // 6: reset during WAIT of hop 2 of the 5 -> 9 chain
        req_valid = 1'b1;
        req_head  = 11'd5;
        req_tuple = rand_tuple();
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_values("t6_midreset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t6_no_resp", 128'(resp_valid), 128'(0));
        end
        run_lookup("t6_after_reset", 11'd5, 0);

        // Randomised tables and heads over indices 0..31
        for (int n = 0; n < 40; n++) begin
            if (n % 8 == 0) begin
                for (int i = 0; i < 32; i++) begin
                    set_entry(i, 1'($urandom_range(0, 1)), 11'($urandom_range(0, 2047)),
                              ($urandom_range(0, 3) == 0) ? NUL : 11'($urandom_range(0, 31)));
                end
            end
            run_lookup("rand",
                       ($urandom_range(0, 7) == 0) ? NUL : 11'($urandom_range(0, 31)),
                       int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule : tb_g3_chain_walker
`default_nettype wire
